data_mem_dump: RTL and testbench

- Read-side companion of the processor's data memory (64 x 32-bit, combinational read port).
- When the core signals end of program, the block captures the final PC value.
- It then walks every memory word in address order and streams them out over a valid/ready interface, for the testbench scoreboard or a debug/UART path.
- Sits beside the data memory and muxes onto its address/read port while the core is halted.

---
 rtl/data_mem_dump_pkg.sv | 26 ++
 rtl/data_mem_dump.sv | 137 +++++++++++++
 tb/tb_data_mem_dump.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_dump_pkg.sv
// Shared constants and types for the data-memory dump engine.
//   DEF_*   : default geometry of the data memory and the dump stream
//   state_e : dump FSM state encoding
//   word_t  : one stream beat (header flag, index, data word)
package data_mem_dump_pkg;

  localparam int unsigned DEF_DEPTH  = 64;
  localparam int unsigned DEF_IDX_W  = 6;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  typedef struct packed {
    logic                  is_hdr;
    logic [DEF_IDX_W-1:0]  idx;
    logic [DEF_DATA_W-1:0] data;
  } word_t;

endpackage

// File: rtl/data_mem_dump.sv
// Data-memory dump engine. On a program-finished pulse it captures the final
// PC, emits it as a header word, then reads every data-memory word in address
// order and streams it over a valid/ready interface.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, pc_final       program-finished pulse and PC captured with it
//   mem_read, mem_addr    read strobe / word address to the data memory
//   mem_data              combinational read data from the data memory
//   mem_hold              high while dumping; core gates its memory writes
//   out_valid/out_ready   stream handshake
//   out_data, out_is_hdr  stream word and header marker
//   out_idx               memory index of the current word (0 for the header)
//   busy, done            activity flag and end-of-dump pulse
module data_mem_dump
  import data_mem_dump_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_final,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_hold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_hdr,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done
);

  state_e             state;
  state_e             state_next;
  logic [IDX_W-1:0]   idx_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [DATA_W-1:0]  data_q;
  logic               xfer_c;
  logic               last_c;

  assign xfer_c = out_valid && out_ready;
  assign last_c = (idx_q == IDX_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)  state_next = ST_HDR;
      ST_HDR:  if (xfer_c) state_next = ST_RD;
      ST_RD:               state_next = ST_SEND;
      ST_SEND: if (xfer_c) state_next = last_c ? ST_FIN : ST_RD;
      ST_FIN:              state_next = ST_IDLE;
      default:             state_next = ST_IDLE;
    endcase
  end

  // Output decode; all outputs are functions of the state and the datapath
  // registers, so they hold steady while the consumer stalls.
  always_comb begin
    mem_read   = 1'b0;
    mem_addr   = ADDR_W'(idx_q);
    out_valid  = 1'b0;
    out_data   = '0;
    out_is_hdr = 1'b0;
    out_idx    = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_HDR: begin
        out_valid  = 1'b1;
        out_is_hdr = 1'b1;
        out_data   = DATA_W'(pc_q);
      end
      ST_RD: begin
        mem_read = 1'b1;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = data_q;
        out_idx   = idx_q;
      end
      ST_FIN: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    mem_hold = busy;
  end

  // Datapath: captured PC, word index and read-data register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc_q  <= pc_final;
            idx_q <= '0;
          end
        end
        ST_RD: begin
          data_q <= mem_data;
        end
        ST_SEND: begin
          // Terminal test on DEPTH-1 keeps idx from ever wrapping.
          if (xfer_c && !last_c) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_dump.sv
// Scoreboard bench for data_mem_dump: stimulus pushes the expected stream
// into a queue, a negedge monitor pops and compares on every transfer.
module tb_data_mem_dump;
  import data_mem_dump_pkg::*;

  localparam int unsigned DEPTH  = DEF_DEPTH;
  localparam int unsigned IDX_W  = DEF_IDX_W;
  localparam int unsigned DATA_W = DEF_DATA_W;
  localparam int unsigned ADDR_W = DEF_ADDR_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] pc_final;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_hold;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_is_hdr;
  logic [IDX_W-1:0]  out_idx;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [DEPTH];
  word_t             exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  logic              held;
  logic [DATA_W-1:0] held_data;
  logic              held_hdr;
  logic [IDX_W-1:0]  held_idx;

  data_mem_dump dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc_final   (pc_final),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_hold   (mem_hold),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_is_hdr (out_is_hdr),
    .out_idx    (out_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr[IDX_W-1:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on transfers, check stability while stalled.
  always @(negedge clk) begin
    word_t e;
    if (reset) begin
      held <= 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'({out_is_hdr, out_idx, out_data}),
            64'({held_hdr, held_idx, held_data}));
      end
      if (out_valid && out_ready) begin
        held <= 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'({out_is_hdr, out_idx, out_data}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word", 64'({out_is_hdr, out_idx, out_data}), 64'(e));
        end
      end else if (out_valid) begin
        held      <= 1'b1;
        held_data <= out_data;
        held_hdr  <= out_is_hdr;
        held_idx  <= out_idx;
      end else begin
        held <= 1'b0;
      end
      if (mem_read) chk("mem_addr_hi", 64'(mem_addr >> IDX_W), 64'd0);
      if (done) done_cnt++;
    end
  end

  task automatic push_dump(input logic [ADDR_W-1:0] pc);
    exp_q.push_back(word_t'{is_hdr: 1'b1, idx: '0, data: DATA_W'(pc)});
    for (int i = 0; i < int'(DEPTH); i++)
      exp_q.push_back(word_t'{is_hdr: 1'b0, idx: IDX_W'(i), data: DATA_W'(i * 4 + 'h100)});
  endtask

  // Called at posedge+#1 with the DUT idle; returns at posedge+#1 in HDR.
  task automatic issue_start(input logic [ADDR_W-1:0] pc);
    start    = 1'b1;
    pc_final = pc;
    @(posedge clk); #1;
    start    = 1'b0;
    pc_final = 32'hBAD0_BAD0;   // must not affect the dump
  endtask

  // Runs until done is seen (FIN), counting busy and hold-low cycles.
  task automatic run_to_done(input bit toggle, input int poke_idx,
                             output int busy_cyc, output int hold_low);
    bit poked = 0;
    bit seen  = 0;
    busy_cyc = 1;
    hold_low = 0;
    for (int c = 0; c < 1000; c++) begin
      if (start) start = 1'b0;
      if (toggle) out_ready = ~out_ready;
      if (!poked && out_valid && !out_is_hdr && int'(out_idx) == poke_idx) begin
        start    = 1'b1;
        pc_final = 32'hDEAD_BEEF;
        poked    = 1;
      end
      @(posedge clk); #1;
      if (busy) busy_cyc++;
      if (!mem_hold) hold_low++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    int bc, hl, bc2, hl2, d0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'(i * 4 + 'h100);
    reset = 1'b1; start = 1'b0; pc_final = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", 64'({mem_read, mem_hold, out_is_hdr, done, out_idx}), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full dump, consumer always ready
    push_dump(32'h268);
    d0 = done_cnt;
    issue_start(32'h268);
    chk("hdr_latency", 64'({out_valid, out_is_hdr, out_data}), 64'({1'b1, 1'b1, 32'h268}));
    run_to_done(0, -1, bc, hl);
    @(posedge clk); #1;
    chk("busy_cycles", 64'(bc), 64'd130);
    chk("idle_after", 64'(busy), 64'd0);
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("q_empty1", 64'(exp_q.size()), 64'd0);

    // Consumer toggling ready every cycle
    push_dump(32'h268);
    d0 = done_cnt;
    issue_start(32'h268);
    run_to_done(1, -1, bc, hl);
    @(posedge clk); #1;
    chk("done_once_tog", 64'(done_cnt - d0), 64'd1);
    chk("q_empty2", 64'(exp_q.size()), 64'd0);

    // Reset while word 20 is on the bus
    exp_q.push_back(word_t'{is_hdr: 1'b1, idx: '0, data: 32'h268});
    for (int i = 0; i < 20; i++)
      exp_q.push_back(word_t'{is_hdr: 1'b0, idx: IDX_W'(i), data: DATA_W'(i * 4 + 'h100)});
    d0 = done_cnt;
    issue_start(32'h268);
    begin
      bit found = 0;
      for (int c = 0; c < 500; c++) begin
        if (out_valid && !out_is_hdr && out_idx == IDX_W'(20)) begin
          found = 1;
          break;
        end
        @(posedge clk); #1;
      end
      chk("reach_idx20", 64'(found), 64'd1);
    end
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    chk("abort_busy", 64'({busy, mem_hold, out_valid, mem_read, done}), 64'd0);
    chk("abort_data", 64'({out_data, out_idx, out_is_hdr}), 64'd0);
    chk("abort_addr", 64'(mem_addr), 64'd0);
    chk("abort_q", 64'(exp_q.size()), 64'd0);
    push_dump(32'h10);
    issue_start(32'h10);
    run_to_done(0, -1, bc, hl);
    @(posedge clk); #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd1);
    chk("q_empty3", 64'(exp_q.size()), 64'd0);

    // Start pulsed mid-dump is ignored
    push_dump(32'h268);
    d0 = done_cnt;
    issue_start(32'h268);
    run_to_done(0, 5, bc, hl);
    @(posedge clk); #1;
    chk("ign_busy_cycles", 64'(bc), 64'd130);
    chk("ign_done_once", 64'(done_cnt - d0), 64'd1);
    chk("ign_idle", 64'(busy), 64'd0);
    chk("q_empty4", 64'(exp_q.size()), 64'd0);

    // Back-to-back dumps with one IDLE cycle between
    push_dump(32'h268);
    push_dump(32'h444);
    d0 = done_cnt;
    issue_start(32'h268);
    run_to_done(0, -1, bc, hl);
    @(posedge clk); #1;
    chk("b2b_gap_hold", 64'({busy, mem_hold}), 64'd0);
    issue_start(32'h444);
    chk("b2b_hdr", 64'({out_valid, out_is_hdr, out_data}), 64'({1'b1, 1'b1, 32'h444}));
    run_to_done(0, -1, bc2, hl2);
    @(posedge clk); #1;
    chk("b2b_hold_low", 64'(hl + hl2 + 1), 64'd1);
    chk("b2b_busy2", 64'(bc2), 64'd130);
    chk("b2b_done", 64'(done_cnt - d0), 64'd2);
    chk("q_empty5", 64'(exp_q.size()), 64'd0);

    // Reset and start together: reset wins
    reset = 1'b1; start = 1'b1; pc_final = 32'h55;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rs_busy", 64'({busy, out_valid}), 64'd0);
    @(posedge clk); #1;
    chk("rs_busy2", 64'({busy, out_valid, mem_hold}), 64'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
